gpr_scoreboard: RTL and testbench

- Tracks in-flight GPR writes between decode issue and writeback, per architectural register.
- Drives the `reg_read_busy` hazard signal consumed by the ID stage's `gpr_read` port.
- Sits beside the GPR file: ID issue increments, writeback/kill decrements, ID source lookups read the table.
- Also stalls issue when a destination's pending-write counter would overflow.

---
 rtl/gpr_scoreboard_pkg.sv | 14 +
 rtl/gpr_scoreboard_if.sv | 34 +++
 rtl/gpr_scoreboard_sb_counter.sv | 51 +++++
 rtl/gpr_scoreboard.sv | 106 ++++++++++
 tb/tb_gpr_scoreboard.sv | 138 +++++++++++++
 5 files changed

// File: rtl/gpr_scoreboard_pkg.sv
// Shared constants and types for the GPR pending-write scoreboard.
package gpr_scoreboard_pkg;

    localparam int NUM_GPR   = 32;  // architectural integer registers, x0 untracked
    localparam int CNT_W     = 2;   // per-register pending counter width
    localparam int TOT_W     = 4;   // total-outstanding counter width
    localparam int GPR_IDX_W = 5;   // register index width

    typedef logic [CNT_W-1:0] sb_cnt_t;

    localparam sb_cnt_t          CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

endpackage

// File: rtl/gpr_scoreboard_if.sv
// ID/WB-side bundle of the GPR scoreboard: source lookups, issue, writeback,
// kill, and the hazard / status outputs.
interface gpr_scoreboard_if;

    logic                                     rs1_en;
    logic [gpr_scoreboard_pkg::GPR_IDX_W-1:0] rs1;
    logic                                     rs2_en;
    logic [gpr_scoreboard_pkg::GPR_IDX_W-1:0] rs2;
    logic                                     id_rd_en;
    logic [gpr_scoreboard_pkg::GPR_IDX_W-1:0] id_rd;
    logic                                     reg_read_busy;
    logic                                     issue_valid;
    logic                                     wb_valid;
    logic [gpr_scoreboard_pkg::GPR_IDX_W-1:0] wb_rd;
    logic                                     kill_valid;
    logic [gpr_scoreboard_pkg::GPR_IDX_W-1:0] kill_rd;
    logic [gpr_scoreboard_pkg::TOT_W-1:0]     outstanding;
    logic                                     sb_err;

    // Pipeline side: drives lookups and events, observes the hazard
    modport master (
        output rs1_en, rs1, rs2_en, rs2, id_rd_en, id_rd,
        output issue_valid, wb_valid, wb_rd, kill_valid, kill_rd,
        input  reg_read_busy, outstanding, sb_err
    );

    // Scoreboard side
    modport slave (
        input  rs1_en, rs1, rs2_en, rs2, id_rd_en, id_rd,
        input  issue_valid, wb_valid, wb_rd, kill_valid, kill_rd,
        output reg_read_busy, outstanding, sb_err
    );

endinterface

// File: rtl/gpr_scoreboard_sb_counter.sv
// One saturating up/down pending-write counter. Accepts +1 and -0/-1/-2 in
// the same cycle, applies the net result, and reports the change actually
// applied plus a saturation error pulse.
module sb_counter
    import gpr_scoreboard_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    input  logic [1:0]       dec_i,
    output sb_cnt_t          cnt_o,
    output logic [CNT_W+1:0] delta_o,
    output logic             err_o
);

    // Two extra bits: one for the +1 carry, one as sign for the -2 borrow.
    localparam int NW = CNT_W + 2;

    sb_cnt_t       cnt_q;
    sb_cnt_t       cnt_d;
    logic [NW-1:0] net_s;

    // Net next value, clamped at 0 and CNT_MAX with an error on either clamp
    always_comb begin
        net_s = {2'b00, cnt_q} + {{(NW-1){1'b0}}, inc_i} - {{(NW-2){1'b0}}, dec_i};
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (net_s[NW-1]) begin
            cnt_d = {CNT_W{1'b0}};
            err_o = 1'b1;
        end else if (net_s[NW-2]) begin
            cnt_d = CNT_MAX;
            err_o = 1'b1;
        end else begin
            cnt_d = net_s[CNT_W-1:0];
        end
        delta_o = {2'b00, cnt_d} - {2'b00, cnt_q};
    end

    // Counter state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gpr_scoreboard.sv
// GPR scoreboard: per-register pending-write counters between ID issue and
// writeback/kill, combinational read hazard for ID, registered total of
// outstanding writes and a sticky protocol-error flag.
module gpr_scoreboard
    import gpr_scoreboard_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    gpr_scoreboard_if.slave sb
);

    localparam int DW = CNT_W + 2;  // per-counter applied delta width (signed)
    localparam int SW = TOT_W + 2;  // total plus net delta (-2..+1), signed

    logic [NUM_GPR-1:0]            inc_s;
    logic [NUM_GPR-1:0][1:0]       dec_s;
    logic [NUM_GPR-1:0][CNT_W-1:0] cnt_s;
    logic [NUM_GPR-1:0][DW-1:0]    delta_s;
    logic [NUM_GPR-1:0]            cnt_err_s;

    logic             src1_busy_s;
    logic             src2_busy_s;
    logic             dst_full_s;
    logic [SW-1:0]    tot_net_s;
    logic             tot_err_s;
    logic [TOT_W-1:0] tot_q;
    logic [TOT_W-1:0] tot_d;
    logic             err_q;
    logic             err_d;

    // Index decode: issue increment and wb/kill decrement per register (x0 never hit)
    always_comb begin
        inc_s = {NUM_GPR{1'b0}};
        dec_s = {(2*NUM_GPR){1'b0}};
        for (int r = 1; r < NUM_GPR; r++) begin
            inc_s[r] = sb.issue_valid && sb.id_rd_en && (sb.id_rd == GPR_IDX_W'(r));
            dec_s[r] = {1'b0, (sb.wb_valid   && (sb.wb_rd   == GPR_IDX_W'(r)))}
                     + {1'b0, (sb.kill_valid && (sb.kill_rd == GPR_IDX_W'(r)))};
        end
    end

    // x0 has no counter; it reads as permanently idle
    assign cnt_s[0]     = {CNT_W{1'b0}};
    assign delta_s[0]   = {DW{1'b0}};
    assign cnt_err_s[0] = 1'b0;

    for (genvar g = 1; g < NUM_GPR; g++) begin : g_cnt
        sb_counter u_cnt (
            .clock   (clock),
            .reset   (reset),
            .inc_i   (inc_s[g]),
            .dec_i   (dec_s[g]),
            .cnt_o   (cnt_s[g]),
            .delta_o (delta_s[g]),
            .err_o   (cnt_err_s[g])
        );
    end

    // Hazard: a source is busy while its count exceeds this cycle's wb/kill
    // (write-through file); destination full uses the raw count on purpose
    always_comb begin
        src1_busy_s = sb.rs1_en && (sb.rs1 != {GPR_IDX_W{1'b0}}) &&
                      ({1'b0, cnt_s[sb.rs1]} > {{(CNT_W-1){1'b0}}, dec_s[sb.rs1]});
        src2_busy_s = sb.rs2_en && (sb.rs2 != {GPR_IDX_W{1'b0}}) &&
                      ({1'b0, cnt_s[sb.rs2]} > {{(CNT_W-1){1'b0}}, dec_s[sb.rs2]});
        dst_full_s  = sb.id_rd_en && (sb.id_rd != {GPR_IDX_W{1'b0}}) &&
                      (cnt_s[sb.id_rd] == CNT_MAX);
    end

    assign sb.reg_read_busy = src1_busy_s || src2_busy_s || dst_full_s;

    // Total: add the deltas the counters actually applied, clamp at 0 / TOT_MAX
    always_comb begin
        tot_net_s = {2'b00, tot_q};
        for (int r = 0; r < NUM_GPR; r++) begin
            tot_net_s = tot_net_s + {{(SW-DW){delta_s[r][DW-1]}}, delta_s[r]};
        end
        tot_d     = tot_q;
        tot_err_s = 1'b0;
        if (tot_net_s[SW-1]) begin
            tot_d     = {TOT_W{1'b0}};
            tot_err_s = 1'b1;
        end else if (tot_net_s[SW-2]) begin
            tot_d     = TOT_MAX;
            tot_err_s = 1'b1;
        end else begin
            tot_d = tot_net_s[TOT_W-1:0];
        end
        err_d = err_q || tot_err_s || (|cnt_err_s);
    end

    // Total counter and sticky error registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tot_q <= {TOT_W{1'b0}};
            err_q <= 1'b0;
        end else begin
            tot_q <= tot_d;
            err_q <= err_d;
        end
    end

    assign sb.outstanding = tot_q;
    assign sb.sb_err      = err_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Scoreboard-style bench for gpr_scoreboard: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_gpr_scoreboard;

    logic clock;
    logic reset;

    gpr_scoreboard_if sbif ();

    gpr_scoreboard dut (
        .clock (clock),
        .reset (reset),
        .sb    (sbif)
    );

    typedef struct {
        string name;
        int    sel;   // 0 reg_read_busy, 1 outstanding, 2 sb_err
        int    exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compare all expectations queued for this cycle
    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t e;
            int   act;
            e = q.pop_front();
            case (e.sel)
                0:       act = int'(sbif.reg_read_busy);
                1:       act = int'(sbif.outstanding);
                default: act = int'(sbif.sb_err);
            endcase
            n_checks++;
            if (act == e.exp) n_pass++;
            else $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
        end
    end

    task automatic ex(input string n, input int sel, input int v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    // One cycle of stimulus, applied 1 time unit after the rising edge
    task automatic drv(input logic r1e, input int r1, input logic r2e, input int r2,
                       input logic rde, input int rd, input logic iss,
                       input logic wbv, input int wbr, input logic kv, input int kr);
        @(posedge clock);
        #1;
        sbif.rs1_en      = r1e;  sbif.rs1     = 5'(r1);
        sbif.rs2_en      = r2e;  sbif.rs2     = 5'(r2);
        sbif.id_rd_en    = rde;  sbif.id_rd   = 5'(rd);
        sbif.issue_valid = iss;
        sbif.wb_valid    = wbv;  sbif.wb_rd   = 5'(wbr);
        sbif.kill_valid  = kv;   sbif.kill_rd = 5'(kr);
    endtask

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected end before 50000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        sbif.rs1_en = 1'b0; sbif.rs1 = 5'd0; sbif.rs2_en = 1'b0; sbif.rs2 = 5'd0;
        sbif.id_rd_en = 1'b0; sbif.id_rd = 5'd0; sbif.issue_valid = 1'b0;
        sbif.wb_valid = 1'b0; sbif.wb_rd = 5'd0; sbif.kill_valid = 1'b0; sbif.kill_rd = 5'd0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state and idle lookup
        drv(1,5, 0,0, 0,0,0, 0,0, 0,0); ex("rst_busy",0,0); ex("rst_out",1,0); ex("rst_err",2,0);
        // Issue rd=5, then RAW hazard, then resolved by same-cycle writeback
        drv(0,0, 0,0, 1,5,1, 0,0, 0,0); ex("iss5_busy",0,0);
        drv(1,5, 0,0, 0,0,0, 0,0, 0,0); ex("raw5_busy",0,1); ex("raw5_out",1,1);
        drv(1,5, 0,0, 0,0,0, 1,5, 0,0); ex("wb5_bypass",0,0); ex("wb5_out",1,1);
        drv(1,5, 0,0, 0,0,0, 0,0, 0,0); ex("after5_busy",0,0); ex("after5_out",1,0);
        // Three writes in flight to x7, then destination full
        drv(0,0, 0,0, 1,7,1, 0,0, 0,0); ex("iss7a_busy",0,0);
        drv(0,0, 0,0, 1,7,1, 0,0, 0,0); ex("iss7b_out",1,1);
        drv(0,0, 0,0, 1,7,1, 0,0, 0,0); ex("iss7c_busy",0,0); ex("iss7c_out",1,2);
        drv(0,0, 0,0, 1,7,0, 0,0, 0,0); ex("dst_full",0,1); ex("full_out",1,3);
        drv(0,0, 0,0, 1,7,0, 1,7, 0,0); ex("full_wb_cons",0,1); ex("full_wb_out",1,3);
        drv(0,0, 0,0, 1,7,1, 1,7, 0,0); ex("reiss7_busy",0,0); ex("reiss7_out",1,2);
        // wb + kill on x7 in one cycle: net -2
        drv(0,0, 0,0, 0,0,0, 1,7, 1,7); ex("wbreiss_out",1,2);
        // Build cnt[3]=2, then inc+wb+kill on x3 together
        drv(0,0, 0,0, 1,3,1, 0,0, 0,0); ex("wbkill7_out",1,0); ex("wbkill7_err",2,0);
        drv(0,0, 0,0, 1,3,1, 0,0, 0,0); ex("iss3b_out",1,1);
        drv(0,0, 0,0, 1,3,1, 1,3, 1,3); ex("triple3_busy",0,0); ex("triple3_pre",1,2);
        drv(1,3, 0,0, 0,0,0, 0,0, 0,0); ex("triple3_busy2",0,1); ex("triple3_out",1,1);
        ex("triple3_err",2,0);
        drv(1,3, 0,0, 0,0,0, 1,3, 0,0); ex("wb3_bypass",0,0); ex("wb3_out",1,1);
        // Index 0 everywhere: never busy, never counted, never an error
        drv(1,0, 1,0, 1,0,1, 1,0, 1,0); ex("x0_busy",0,0); ex("x0_out_pre",1,0);
        drv(0,0, 0,0, 1,12,1, 0,0, 0,0); ex("x0_out",1,0); ex("x0_err",2,0);
        // rs2 path, resolved by a same-cycle kill
        drv(0,0, 1,12, 0,0,0, 0,0, 0,0); ex("rs2_busy",0,1); ex("rs2_out",1,1);
        drv(0,0, 1,12, 0,0,0, 0,0, 1,12); ex("kill12_bypass",0,0); ex("kill12_out",1,1);
        // Underflow on x9: error set and sticky, count stays 0
        drv(0,0, 0,0, 0,0,0, 1,9, 0,0); ex("uf_busy",0,0); ex("uf_out_pre",1,0);
        ex("uf_err_pre",2,0);
        drv(1,9, 0,0, 0,0,0, 0,0, 0,0); ex("uf_cnt9",0,0); ex("uf_out",1,0); ex("uf_err",2,1);
        // Build cnt[4]=2, then asynchronous reset mid-cycle
        drv(0,0, 0,0, 1,4,1, 0,0, 0,0); ex("sticky_err",2,1);
        drv(0,0, 0,0, 1,4,1, 0,0, 0,0); ex("iss4b_out",1,1);
        drv(1,4, 0,0, 0,0,0, 0,0, 0,0); ex("raw4_busy",0,1); ex("raw4_out",1,2);
        drv(1,4, 0,0, 0,0,0, 0,0, 0,0);
        reset = 1'b1;
        ex("arst_out",1,0); ex("arst_err",2,0); ex("arst_busy",0,0);
        drv(1,4, 0,0, 0,0,0, 0,0, 0,0);
        reset = 1'b0;
        ex("post_rst_busy",0,0); ex("post_rst_out",1,0); ex("post_rst_err",2,0);

        @(posedge clock);
        @(negedge clock);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
